// File: rtl/repeat_button_conditioner_pkg.sv
// Shared flasher-side definitions: debounce FSM state encodings (2-bit, also used by
// other flasher blocks), default timing constants and a small sizing helper.
package repeat_button_conditioner_pkg;

    // Debounce FSM states
    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Default timing constants
    localparam int DEF_DEBOUNCE_CYCLES = 20;
    localparam int DEF_HOLD_CYCLES     = 100;
    localparam int DEF_REPEAT_CYCLES   = 50;
    localparam int DEF_CNT_W           = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/repeat_button_conditioner_if.sv
// Button-side bundle: raw button in, conditioned pulse / level / press count out.
// master = the board/test side driving the button, slave = the conditioner.
interface repeat_button_conditioner_if
    import repeat_button_conditioner_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             btn_raw;
    logic             repeat_signal;
    logic             btn_level;
    logic [CNT_W-1:0] press_count;

    modport master (output btn_raw, input repeat_signal, input btn_level, input press_count);
    modport slave  (input btn_raw, output repeat_signal, output btn_level, output press_count);
endinterface

// File: rtl/repeat_button_conditioner_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/repeat_button_conditioner.sv
// Push-button conditioner for the ring flasher: synchronise, debounce, and emit one-cycle
// repeat_signal pulses per accepted press, plus debounced level and a wrapping press count.
// Optional build macro AUTO_REPEAT_EN: while held, emit further pulses after HOLD_CYCLES
// and then every REPEAT_CYCLES (each also counted in press_count).
module repeat_button_conditioner
    import repeat_button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    repeat_button_conditioner_if.slave    bus
);
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q;
    logic [1:0]       state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             repeat_q, repeat_d;
    logic [CNT_W-1:0] press_count_q, press_count_d;
    logic             press_evt;  // debounced press accepted on this edge
    logic             auto_evt;   // auto-repeat pulse due on this edge

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.btn_raw),
        .q_o   (sync_q)
    );

    // Debounce FSM: a level change is accepted after DEBOUNCE_CYCLES consecutive
    // mismatching samples; any agreeing sample in between restarts the wait.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        btn_level_d = btn_level_q;
        press_evt   = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (sync_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d     = ST_PRESSED;
                        db_cnt_d    = '0;
                        btn_level_d = 1'b1;
                        press_evt   = 1'b1;
                    end else begin
                        state_d  = ST_PRESS_WAIT;
                        db_cnt_d = DB_ONE;
                    end
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d  = ST_RELEASED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_PRESSED;
                    db_cnt_d    = '0;
                    btn_level_d = 1'b1;
                    press_evt   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            ST_PRESSED: begin
                if (!sync_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d     = ST_RELEASED;
                        db_cnt_d    = '0;
                        btn_level_d = 1'b0;
                    end else begin
                        state_d  = ST_RELEASE_WAIT;
                        db_cnt_d = DB_ONE;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d  = ST_PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_RELEASED;
                    db_cnt_d    = '0;
                    btn_level_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: begin
                // Unreachable with 2-bit encoding; recover without touching outputs.
                state_d  = ST_RELEASED;
                db_cnt_d = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int               RPT_W    = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
    localparam logic [RPT_W-1:0] HOLD_END = RPT_W'(HOLD_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_END  = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;  // 0: waiting HOLD, 1: repeating

    // Auto-repeat timer: counts only on edges that stay in PRESSED, so a pending release
    // freezes it and a release on the due edge suppresses the pulse. The !repeat_q guard
    // keeps pulses apart when an interval of 1 is configured.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        auto_evt    = 1'b0;
        if (press_evt || state_q == ST_RELEASED) begin
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b0;
        end else if (state_q == ST_PRESSED && sync_q) begin
            if (rpt_cnt_q == (rpt_phase_q ? RPT_END : HOLD_END)) begin
                rpt_cnt_d   = '0;
                rpt_phase_d = 1'b1;
                auto_evt    = !repeat_q;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_ONE;
            end
        end
    end

    // Auto-repeat timer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`else
    assign auto_evt = 1'b0;
`endif

    // Pulse and counter next-state: every emitted pulse is counted.
    always_comb begin
        repeat_d      = press_evt | auto_evt;
        press_count_d = repeat_d ? press_count_q + CNT_W'(1) : press_count_q;
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RELEASED;
            db_cnt_q      <= '0;
            btn_level_q   <= 1'b0;
            repeat_q      <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
            btn_level_q   <= btn_level_d;
            repeat_q      <= repeat_d;
            press_count_q <= press_count_d;
        end
    end

    assign bus.repeat_signal = repeat_q;
    assign bus.btn_level     = btn_level_q;
    assign bus.press_count   = press_count_q;

endmodule

// File: tb/tb_repeat_button_conditioner.sv
// Bench for repeat_button_conditioner: table vectors, hand sequences for the corner
// cases, and random button activity checked against a run-length reference model.
module tb_repeat_button_conditioner;
    localparam int D  = 4;
    localparam int H  = 10;
    localparam int R  = 5;
    localparam int CW = 8;
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        bit          btn;
        bit          rep;
        bit          lvl;
        logic [CW-1:0] cnt;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    repeat_button_conditioner_if #(.CNT_W(CW)) bus ();

    repeat_button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R),
        .CNT_W           (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int edge_no, npulse, pulse_at, drops;
    int dbl = 0;
    bit prev_rep, prev_lvl;

    // Reference model: sync delay as a 2-deep sample history, debouncing as a count of
    // consecutive samples disagreeing with the accepted level, auto-repeat from the
    // number of steady held samples since the press.
    bit            m_h0, m_h1, m_level, m_rep;
    int            m_run, m_held;
    logic [CW-1:0] m_cnt;

    task automatic model_reset();
        m_h0 = 0; m_h1 = 0; m_level = 0; m_rep = 0;
        m_run = 0; m_held = 0; m_cnt = '0;
    endtask

    task automatic model_edge(input bit b);
        bit s;
        s = m_h1; m_h1 = m_h0; m_h0 = b; m_rep = 0;
        if (s != m_level) begin
            m_run++;
            if (m_run == D) begin
                m_level = s; m_run = 0;
                if (s) begin m_rep = 1; m_held = 0; end
            end
        end else begin
            if (m_level && m_run == 0) begin
                m_held++;
                if (AUTO && (m_held == H || (m_held > H && (m_held - H) % R == 0)))
                    m_rep = 1;
            end
            m_run = 0;
        end
        if (m_rep) m_cnt++;
    endtask

    function automatic int outs();
        return 32'({bus.repeat_signal, bus.btn_level, bus.press_count});
    endfunction

    function automatic int model_outs();
        return 32'({m_rep, m_level, m_cnt});
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive the button, take the edge, advance the model, sample at +1.
    task automatic step(input bit b);
        bus.btn_raw = b;
        @(posedge clk);
        model_edge(b);
        #1;
        edge_no++;
        if (bus.repeat_signal) begin
            npulse++;
            pulse_at = edge_no;
            if (prev_rep) dbl++;
        end
        if (prev_lvl && !bus.btn_level) drops++;
        prev_rep = bus.repeat_signal;
        prev_lvl = bus.btn_level;
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic do_reset(input bit b);
        bus.btn_raw = b;
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", outs(), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        edge_no = 0; npulse = 0; pulse_at = -1; drops = 0;
        prev_rep = 0; prev_lvl = 0;
    endtask

    initial begin
        vec_t tbl[16];
        bus.btn_raw = 1'b0;
        #2;
        do_reset(0);

        // Clean press then release: level/pulse/count edge by edge.
        for (int i = 0; i < 16; i++) begin
            tbl[i].btn = (i < 8);
            tbl[i].rep = (i == 5);
            tbl[i].lvl = (i >= 5 && i <= 12);
            tbl[i].cnt = (i >= 5) ? 8'd1 : 8'd0;
        end
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].btn);
            chk($sformatf("vec%0d", i), outs(), 32'({tbl[i].rep, tbl[i].lvl, tbl[i].cnt}));
        end

        // Bounce: 3 high, 1 low, 3 high, then low -> nothing accepted.
        do_reset(0);
        hold(1, 3); hold(0, 1); hold(1, 3); hold(0, 10);
        chk("bounce_pulses", npulse, 0);
        chk("bounce_level", 32'(bus.btn_level), 0);
        chk("bounce_count", 32'(bus.press_count), 0);

        // Release glitch of 2 cycles while held.
        do_reset(0);
        hold(1, 10); hold(0, 2); hold(1, 10);
        chk("glitch_level_drops", drops, 0);
        chk("glitch_level", 32'(bus.btn_level), 1);
        chk("glitch_pulses", npulse, AUTO ? 2 : 1);

        // Long hold: release reaches the FSM exactly on the edge a repeat would be due.
        do_reset(0);
        hold(1, 43); hold(0, 10);
        chk("hold_pulses", npulse, AUTO ? 7 : 1);
        chk("hold_count", 32'(bus.press_count), AUTO ? 7 : 1);
        chk("hold_last_pulse", pulse_at, AUTO ? 41 : 6);
        chk("hold_level_after", 32'(bus.btn_level), 0);

        // Reset while the button stays held: re-debounced from scratch.
        do_reset(0);
        hold(1, 10);
        chk("pre_rst_count", 32'(bus.press_count), 1);
        do_reset(1);
        hold(1, 8);
        chk("rst_pulse_edge", pulse_at, 6);
        chk("rst_count", 32'(bus.press_count), 1);

        // 256 clean presses wrap the counter.
        do_reset(0);
        for (int i = 0; i < 256; i++) begin
            hold(1, 8); hold(0, 8);
        end
        chk("wrap_pulses", npulse, 256);
        chk("wrap_count", 32'(bus.press_count), 0);

        // Random bursts against the model, compared every edge.
        do_reset(0);
        for (int k = 0; k < 300; k++) begin
            bit b;
            int len;
            b   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 45))
                                              : int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) begin
                step(b);
                chk("rand", outs(), model_outs());
            end
        end

        chk("no_back_to_back_pulses", dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
